// File: rtl/aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | aes_key_expand: AES-128 key schedule, one round key per cycle with        |
// | valid/ready handoff to the AddRoundKey stage.  Rev 1.0                     |
// +----------------------------------------------------------------------------+
module aes_key_expand (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_in,
  output logic         busy,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         done
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [3:0] c_last_idx = 4'd10;

  // Element 0 sits at the MSB end, so c_sbox[b] is S(b).
  localparam logic [0:255][7:0] c_sbox = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] rcon(input logic [3:0] n);
    case (n)
      4'd1:    rcon = 8'h01;
      4'd2:    rcon = 8'h02;
      4'd3:    rcon = 8'h04;
      4'd4:    rcon = 8'h08;
      4'd5:    rcon = 8'h10;
      4'd6:    rcon = 8'h20;
      4'd7:    rcon = 8'h40;
      4'd8:    rcon = 8'h80;
      4'd9:    rcon = 8'h1b;
      4'd10:   rcon = 8'h36;
      default: rcon = 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    sub_word = {c_sbox[w[31:24]], c_sbox[w[23:16]], c_sbox[w[15:8]], c_sbox[w[7:0]]};
  endfunction

  state_t       r_state;
  state_t       w_state_nxt;
  logic [127:0] w_rk_out_nxt;
  logic [3:0]   w_rk_idx_nxt;
  logic         w_rk_valid_nxt;
  logic         w_busy_nxt;
  logic         w_done_nxt;

  logic [3:0]   w_idx_inc;
  logic [31:0]  w_rot;
  logic [31:0]  w_t;
  logic [31:0]  w_n0;
  logic [31:0]  w_n1;
  logic [31:0]  w_n2;
  logic [31:0]  w_n3;

  // Next round key derived from the key currently presented on rk_out.
  assign w_idx_inc = rk_idx + 4'd1;
  assign w_rot     = {rk_out[23:0], rk_out[31:24]};
  assign w_t       = sub_word(w_rot) ^ {rcon(w_idx_inc), 24'h000000};
  assign w_n0      = rk_out[127:96] ^ w_t;
  assign w_n1      = rk_out[95:64]  ^ w_n0;
  assign w_n2      = rk_out[63:32]  ^ w_n1;
  assign w_n3      = rk_out[31:0]   ^ w_n2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_rk_out_nxt   = rk_out;
    w_rk_idx_nxt   = rk_idx;
    w_rk_valid_nxt = rk_valid;
    w_busy_nxt     = busy;
    w_done_nxt     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt    = RUN;
          w_rk_out_nxt   = key_in;
          w_rk_idx_nxt   = 4'd0;
          w_rk_valid_nxt = 1'b1;
          w_busy_nxt     = 1'b1;
        end
      end
      RUN: begin
        if (rk_valid && rk_ready) begin
          if (rk_idx == c_last_idx) begin
            // Key 10 stays on rk_out/rk_idx after returning to IDLE.
            w_state_nxt    = IDLE;
            w_rk_valid_nxt = 1'b0;
            w_busy_nxt     = 1'b0;
            w_done_nxt     = 1'b1;
          end else begin
            w_rk_out_nxt = {w_n0, w_n1, w_n2, w_n3};
            w_rk_idx_nxt = w_idx_inc;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_out   <= 128'h0;
      rk_idx   <= 4'd0;
      rk_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      rk_out   <= w_rk_out_nxt;
      rk_idx   <= w_rk_idx_nxt;
      rk_valid <= w_rk_valid_nxt;
      busy     <= w_busy_nxt;
      done     <= w_done_nxt;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_key_expand.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_aes_key_expand: scoreboard bench for aes_key_expand.  Rev 1.0           |
// +----------------------------------------------------------------------------+
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         done;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] c_k1     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] c_k1_r1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] c_k1_r2  = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] c_k1_r10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] c_k2     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] c_k2_r10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] c_z_r1   = 128'h62636363626363636263636362636363;
  localparam logic [127:0] c_pt     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] c_ark    = 128'h193de3bea0f4e22b9ac68d2ae9f84808;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    bit           chk;
  } exp_t;

  exp_t         sb[$];
  logic [127:0] r_idx0_seen;

  aes_key_expand dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key_in   (key_in),
    .busy     (busy),
    .rk_valid (rk_valid),
    .rk_ready (rk_ready),
    .rk_out   (rk_out),
    .rk_idx   (rk_idx),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Expected transfers for one expansion; only published keys are compared.
  task automatic load_sb(input logic [127:0] k0, input logic [127:0] r1, input logic [127:0] r2,
                         input logic [127:0] r10, input logic [2:0] known);
    sb.delete();
    for (int i = 0; i <= 10; i++) begin
      exp_t e;
      e.idx = 4'(i);
      e.key = (i == 0) ? k0 : (i == 1) ? r1 : (i == 2) ? r2 : (i == 10) ? r10 : 128'h0;
      e.chk = (i == 0) || (i == 1 && known[0]) || (i == 2 && known[1]) || (i == 10 && known[2]);
      sb.push_back(e);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; rk_ready = 1'b0; key_in = 128'h0;
    #3;
    checks++;
    if ({rk_valid, busy, done, rk_idx} !== 7'h0) begin
      errors++;
      $display("FAIL reset_ctrl got valid=%b busy=%b done=%b idx=%0d want all 0", rk_valid, busy, done, rk_idx);
    end
    checks++;
    if (rk_out !== 128'h0) begin errors++; $display("FAIL reset_rk_out got %h want 0", rk_out); end
    step; step;
    rst = 1'b0;
    step;
  endtask

  task automatic test_fips;
    load_sb(c_k1, c_k1_r1, c_k1_r2, c_k1_r10, 3'b111);
    key_in = c_k1; start = 1'b1; rk_ready = 1'b1;
    step;
    start = 1'b0; key_in = 128'h0;
    for (int i = 0; i <= 10; i++) begin
      exp_t e;
      checks++;
      if (rk_valid !== 1'b1 || busy !== 1'b1 || sb.size() == 0) begin
        errors++;
        $display("FAIL fips_stream cycle %0d got valid=%b busy=%b want 1/1", i, rk_valid, busy);
      end else begin
        e = sb.pop_front();
        checks++;
        if (rk_idx !== e.idx || (e.chk && rk_out !== e.key)) begin
          errors++;
          $display("FAIL fips_key cycle %0d got idx=%0d key=%h want idx=%0d key=%h", i, rk_idx, rk_out, e.idx, e.key);
        end
      end
      if (i == 0) r_idx0_seen = rk_out;
      step;
    end
    checks++;
    if ({done, rk_valid, busy} !== 3'b100 || rk_idx !== 4'd10 || rk_out !== c_k1_r10) begin
      errors++;
      $display("FAIL fips_done got done=%b valid=%b busy=%b idx=%0d key=%h want 1/0/0 10 %h", done, rk_valid, busy, rk_idx, rk_out, c_k1_r10);
    end
    step;
    checks++;
    if (done !== 1'b0 || rk_idx !== 4'd10 || rk_out !== c_k1_r10) begin
      errors++;
      $display("FAIL fips_idle_hold got done=%b idx=%0d key=%h want 0 10 %h", done, rk_idx, rk_out, c_k1_r10);
    end
  endtask

  task automatic test_plaintext;
    checks++;
    if ((c_pt ^ r_idx0_seen) !== c_ark) begin
      errors++;
      $display("FAIL plaintext_ark got %h want %h", c_pt ^ r_idx0_seen, c_ark);
    end
  endtask

  task automatic test_stall;
    exp_t e;
    load_sb(c_k1, c_k1_r1, c_k1_r2, c_k1_r10, 3'b111);
    key_in = c_k1; start = 1'b1; rk_ready = 1'b1;
    step;
    start = 1'b0;
    e = sb.pop_front();
    checks++;
    if (rk_valid !== 1'b1 || rk_idx !== e.idx || rk_out !== e.key) begin
      errors++;
      $display("FAIL stall_idx0 got valid=%b idx=%0d key=%h want 1 0 %h", rk_valid, rk_idx, rk_out, e.key);
    end
    step;
    rk_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step;
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'd1 || rk_out !== c_k1_r1) begin
        errors++;
        $display("FAIL stall_hold cycle %0d got valid=%b idx=%0d key=%h want 1 1 %h", j, rk_valid, rk_idx, rk_out, c_k1_r1);
      end
    end
    rk_ready = 1'b1;
    for (int c = 0; c < 20 && !done; c++) begin
      if (rk_valid && rk_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rk_idx !== e.idx || (e.chk && rk_out !== e.key)) begin
          errors++;
          $display("FAIL stall_key got idx=%0d key=%h want idx=%0d key=%h", rk_idx, rk_out, e.idx, e.key);
        end
      end
      step;
    end
    checks++;
    if (done !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_done got done=%b pending=%0d want 1 0", done, sb.size());
    end
    step;
  endtask

  task automatic test_reset_mid;
    bit   saw_bad;
    exp_t e;
    key_in = c_k1; start = 1'b1; rk_ready = 1'b1;
    step;
    start = 1'b0;
    for (int c = 0; c < 12 && rk_idx != 4'd5; c++) step;
    checks++;
    if (rk_idx !== 4'd5) begin errors++; $display("FAIL rstmid_reach got idx=%0d want 5", rk_idx); end
    rst = 1'b1;
    #1;
    checks++;
    if ({rk_valid, busy, done, rk_idx} !== 7'h0 || rk_out !== 128'h0) begin
      errors++;
      $display("FAIL rstmid_async got valid=%b busy=%b done=%b idx=%0d key=%h want all 0", rk_valid, busy, done, rk_idx, rk_out);
    end
    step;
    rst = 1'b0;
    saw_bad = 1'b0;
    for (int c = 0; c < 4; c++) begin
      step;
      if (done !== 1'b0 || rk_valid !== 1'b0) saw_bad = 1'b1;
    end
    checks++;
    if (saw_bad) begin errors++; $display("FAIL rstmid_nodone got a done or valid pulse after abort want none"); end
    load_sb(c_k1, c_k1_r1, c_k1_r2, c_k1_r10, 3'b111);
    key_in = c_k1; start = 1'b1;
    step;
    start = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      if (rk_valid && rk_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rk_idx !== e.idx || (e.chk && rk_out !== e.key)) begin
          errors++;
          $display("FAIL rstmid_restart got idx=%0d key=%h want idx=%0d key=%h", rk_idx, rk_out, e.idx, e.key);
        end
      end
      step;
    end
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL rstmid_done got done=%b want 1", done); end
    step;
  endtask

  // Ends on the cycle where done is high so the next expansion can start immediately.
  task automatic test_restart_ignored;
    exp_t e;
    int   c;
    load_sb(c_k2, 128'h0, 128'h0, c_k2_r10, 3'b100);
    key_in = c_k2; start = 1'b1; rk_ready = 1'b1;
    step;
    key_in = {128{1'b1}};
    for (c = 0; c < 20 && !done; c++) begin
      start = (rk_valid && rk_idx == 4'd3);
      if (rk_valid && rk_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rk_idx !== e.idx || (e.chk && rk_out !== e.key)) begin
          errors++;
          $display("FAIL restart_key got idx=%0d key=%h want idx=%0d key=%h", rk_idx, rk_out, e.idx, e.key);
        end
      end
      step;
    end
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || c != 11 || sb.size() != 0) begin
      errors++;
      $display("FAIL restart_timing got done=%b cycles=%0d pending=%0d want 1 11 0", done, c, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    exp_t e;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_pre got done=%b busy=%b want 1 0", done, busy);
    end
    load_sb(128'h0, c_z_r1, 128'h0, 128'h0, 3'b001);
    key_in = 128'h0; start = 1'b1; rk_ready = 1'b1;
    step;
    start = 1'b0;
    checks++;
    if (rk_valid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept got valid=%b busy=%b want 1 1", rk_valid, busy);
    end
    for (int c = 0; c < 20 && !done; c++) begin
      if (rk_valid && rk_ready && sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (rk_idx !== e.idx || (e.chk && rk_out !== e.key)) begin
          errors++;
          $display("FAIL b2b_key got idx=%0d key=%h want idx=%0d key=%h", rk_idx, rk_out, e.idx, e.key);
        end
      end
      step;
    end
    checks++;
    if (done !== 1'b1 || sb.size() != 0) begin
      errors++;
      $display("FAIL b2b_done got done=%b pending=%0d want 1 0", done, sb.size());
    end
    step;
  endtask

  initial begin
    test_reset();
    test_fips();
    test_plaintext();
    test_stall();
    test_reset_mid();
    test_restart_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
